// File: rtl/tap_mac_detect_if.sv
// Bundle between the delay-line/driver side and the tap MAC detector.
// master: drives shift and the four taps, observes the detector results.
// slave : the detector; consumes shift/taps, drives sum/sum_valid/above/primed/hit_count.
interface tap_mac_detect_if;
  logic       shift;
  logic [3:0] tap0;
  logic [3:0] tap1;
  logic [3:0] tap2;
  logic [3:0] tap3;
  logic [9:0] sum;
  logic       sum_valid;
  logic       above;
  logic       primed;
  logic [7:0] hit_count;

  modport master (
    output shift, tap0, tap1, tap2, tap3,
    input  sum, sum_valid, above, primed, hit_count
  );

  modport slave (
    input  shift, tap0, tap1, tap2, tap3,
    output sum, sum_valid, above, primed, hit_count
  );
endinterface

// File: rtl/tap_mac_detect.sv
// Purpose: weighted sum of four delay-line taps, thresholded, gated until the line is refilled.
// Latency: shift in cycle T -> sum_valid in cycle T+4 (taps sampled one cycle after shift).
// Backpressure: none; accepts a sample every cycle, gaps in shift reappear as gaps in sum_valid.
// Ports: clk, rst (sync, active-high); bus.shift/tap0..tap3 in; bus.sum, sum_valid, above,
//        primed, hit_count out.
module tap_mac_detect #(
  parameter logic [3:0] COEF0      = 4'd1,
  parameter logic [3:0] COEF1      = 4'd2,
  parameter logic [3:0] COEF2      = 4'd2,
  parameter logic [3:0] COEF3      = 4'd1,
  parameter logic [9:0] THRESH     = 10'd64,
  parameter int         FILL_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  tap_mac_detect_if.slave  bus
);

  localparam logic [6:0] FILL_MAX = 7'(FILL_DEPTH);

  logic       shift_d;
  logic [6:0] fill_cnt;
  logic [6:0] fill_nxt;

  // S1: products + tag
  logic [7:0] p0, p1, p2, p3;
  logic       v1;
  // S2: pair sums
  logic [8:0] pair0, pair1;
  logic       v2;
  // S3: outputs
  logic [9:0] sum_r;
  logic [9:0] sum_nxt;
  logic       sum_valid_r;
  logic       above_r;
  logic       primed_r;
  logic [7:0] hit_r;

  // Fill counter saturates at FILL_DEPTH; it counts shifts since reset because
  // the delay line itself is never cleared.
  always_comb begin
    fill_nxt = fill_cnt;
    if (bus.shift && (fill_cnt != FILL_MAX)) begin
      fill_nxt = fill_cnt + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_d  <= 1'b0;
      fill_cnt <= 7'd0;
      primed_r <= 1'b0;
    end else begin
      shift_d  <= bus.shift;
      fill_cnt <= fill_nxt;
      primed_r <= (fill_nxt == FILL_MAX);
    end
  end

  // Taps are sampled one cycle after shift so they reflect the post-shift
  // contents. fill_cnt at that edge already includes the shift being sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= shift_d && (fill_cnt == FILL_MAX);
    end
  end

  always_ff @(posedge clk) begin
    p0 <= {4'd0, bus.tap0} * {4'd0, COEF0};
    p1 <= {4'd0, bus.tap1} * {4'd0, COEF1};
    p2 <= {4'd0, bus.tap2} * {4'd0, COEF2};
    p3 <= {4'd0, bus.tap3} * {4'd0, COEF3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    pair0 <= {1'b0, p0} + {1'b0, p1};
    pair1 <= {1'b0, p2} + {1'b0, p3};
  end

  // 4*15*15 = 900 fits in 10 bits, so the final add cannot overflow.
  assign sum_nxt = {1'b0, pair0} + {1'b0, pair1};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= 10'd0;
      sum_valid_r <= 1'b0;
      above_r     <= 1'b0;
    end else begin
      sum_valid_r <= v2;
      if (v2) begin
        sum_r   <= sum_nxt;
        above_r <= (sum_nxt >= THRESH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_r <= 8'd0;
    end else if (sum_valid_r && above_r && (hit_r != 8'hFF)) begin
      hit_r <= hit_r + 8'd1;
    end
  end

  assign bus.sum       = sum_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.above     = above_r;
  assign bus.primed    = primed_r;
  assign bus.hit_count = hit_r;

endmodule

// File: tb/tb_tap_mac_detect.sv
module tb_tap_mac_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift;
  logic [3:0] sr_in;
  logic [3:0] dl [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tap_mac_detect_if if_a ();
  tap_mac_detect_if if_b ();

  assign if_a.shift = shift;
  assign if_a.tap0  = dl[15];
  assign if_a.tap1  = dl[31];
  assign if_a.tap2  = dl[47];
  assign if_a.tap3  = dl[63];
  assign if_b.shift = shift;
  assign if_b.tap0  = dl[15];
  assign if_b.tap1  = dl[31];
  assign if_b.tap2  = dl[47];
  assign if_b.tap3  = dl[63];

  tap_mac_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  tap_mac_detect #(
    .COEF0 (4'd15), .COEF1 (4'd15), .COEF2 (4'd15), .COEF3 (4'd15)
  ) dut_max (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Per cycle history of what happened at each edge; a shift at edge c yields a
  // result visible 4 cycles after the shift cycle provided no reset occurs in between.
  bit rst_h [4096];
  bit tag_h [4096];
  int esum_h [4096];
  int esum2_h [4096];
  int cyc = 0;
  int shifts = 0;
  bit model_ok = 0;
  bit m_valid = 0, m_above = 0, m_primed = 0;
  int m_sum = 0, m_sum2 = 0, m_hits = 0;

  always @(posedge clk) begin
    int t0, t1, t2, t3, c;
    bit ev;
    c = cyc % 4096;
    // taps after this edge's shift (if any)
    if (shift) begin
      t0 = dl[14]; t1 = dl[30]; t2 = dl[46]; t3 = dl[62];
    end else begin
      t0 = dl[15]; t1 = dl[31]; t2 = dl[47]; t3 = dl[63];
    end
    rst_h[c] = rst;
    if (rst) shifts = 0;
    else if (shift && shifts < 64) shifts++;
    tag_h[c]   = shift && !rst && (shifts == 64);
    esum_h[c]  = t0 * 1 + t1 * 2 + t2 * 2 + t3 * 1;
    esum2_h[c] = 15 * (t0 + t1 + t2 + t3);

    ev = 0;
    if (cyc >= 3)
      ev = tag_h[(cyc - 3) % 4096] && !rst_h[(cyc - 2) % 4096] &&
           !rst_h[(cyc - 1) % 4096] && !rst;

    if (rst) begin
      m_hits = 0; m_sum = 0; m_sum2 = 0; m_above = 0; m_valid = 0;
    end else begin
      if (m_valid && m_above && m_hits < 255) m_hits++;
      m_valid = ev;
      if (ev) begin
        m_sum   = esum_h[(cyc - 3) % 4096];
        m_sum2  = esum2_h[(cyc - 3) % 4096];
        m_above = (m_sum >= 64);
      end
    end
    m_primed = (shifts == 64);

    if (shift) begin
      for (int k = 63; k > 0; k--) dl[k] <= dl[k-1];
      dl[0] <= sr_in;
    end
    cyc++;
    model_ok = 1;
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      chk("sum_valid", int'(if_a.sum_valid), int'(m_valid));
      chk("sum",       int'(if_a.sum),       m_sum);
      chk("above",     int'(if_a.above),     int'(m_above));
      chk("primed",    int'(if_a.primed),    int'(m_primed));
      chk("hit_count", int'(if_a.hit_count), m_hits);
      chk("max_valid", int'(if_b.sum_valid), int'(m_valid));
      chk("max_sum",   int'(if_b.sum),       m_sum2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, vcount, h0;
    bit [15:0] vmask;
    for (int i = 0; i < 64; i++) dl[i] = 4'($urandom);
    rst = 1'b1; shift = 1'b0; sr_in = 4'd0;

    // reset with shift toggling
    for (int i = 0; i < 3; i++) begin
      shift = i[0]; sr_in = 4'($urandom);
      tick();
      chk("rst_sum_valid", int'(if_a.sum_valid), 0);
      chk("rst_sum",       int'(if_a.sum),       0);
      chk("rst_primed",    int'(if_a.primed),    0);
      chk("rst_hits",      int'(if_a.hit_count), 0);
    end
    rst = 1'b0; shift = 1'b0;
    tick();
    chk("post_rst_primed", int'(if_a.primed), 0);
    chk("post_rst_valid",  int'(if_a.sum_valid), 0);

    // fill gating with input 1
    shift = 1'b1; sr_in = 4'd1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) chk("primed_at_63", int'(if_a.primed), 0);
    end
    chk("primed_at_64", int'(if_a.primed), 1);
    k = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_a.sum_valid) begin k = i; break; end
    end
    chk("first_valid_latency", k, 2);
    chk("first_sum", int'(if_a.sum), 6);
    chk("first_above", int'(if_a.above), 0);

    // constant 15
    sr_in = 4'd15;
    for (int i = 0; i < 68; i++) tick();
    chk("sum_15", int'(if_a.sum), 90);
    chk("above_15", int'(if_a.above), 1);
    chk("sum_15_maxcoef", int'(if_b.sum), 900);
    h0 = int'(if_a.hit_count);
    tick();
    chk("hit_step", int'(if_a.hit_count), h0 + 1);

    // gapped shifts at relative cycles 0, 3, 4
    shift = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vmask = '0;
    for (int i = 0; i < 12; i++) begin
      shift = (i == 0 || i == 3 || i == 4);
      sr_in = 4'($urandom);
      tick();
      vmask[i+1] = if_a.sum_valid;
    end
    chk("gap_valid_mask", int'(vmask), int'(16'h0190));

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      shift = ($urandom % 3) != 0;
      sr_in = 4'($urandom);
      rst   = ($urandom % 60) == 0;
      tick();
    end
    rst = 1'b0;

    // reset mid-stream: prime, shift once, reset two cycles later
    shift = 1'b1;
    for (int i = 0; i < 64; i++) begin sr_in = 4'($urandom); tick(); end
    shift = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    shift = 1'b1; tick();
    shift = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_primed", int'(if_a.primed), 0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin tick(); vcount += int'(if_a.sum_valid); end
    shift = 1'b1;
    for (int i = 0; i < 63; i++) begin sr_in = 4'($urandom); tick(); vcount += int'(if_a.sum_valid); end
    shift = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); vcount += int'(if_a.sum_valid); end
    chk("mid_rst_no_valid", vcount, 0);
    shift = 1'b1; tick();
    shift = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); vcount += int'(if_a.sum_valid); end
    chk("refill_one_valid", vcount, 1);

    // saturation
    shift = 1'b1; sr_in = 4'd15;
    for (int i = 0; i < 300; i++) tick();
    chk("hit_sat", int'(if_a.hit_count), 255);
    for (int i = 0; i < 5; i++) tick();
    chk("hit_sat_hold", int'(if_a.hit_count), 255);
    shift = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
